// File: rtl/solitaire_move_player_if.sv
// solitaire_move_player_if: host move-byte valid/ready stream into the move player
interface solitaire_move_player_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  modport master (output in_valid, output in_data, input in_ready);
  modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/solitaire_move_player.sv
// solitaire_move_player: queues host move bytes and plays them one at a time into the peg solitaire engine; optional SOLITAIRE_PLAYER_REJECT_LOG_EN keeps the last rejected byte
module solitaire_move_player #(
  parameter int FIFO_DEPTH = 4,
  parameter int REJ_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  solitaire_move_player_if.slave host,
  output logic [2:0]           piece_x,
  output logic [2:0]           piece_y,
  output logic [1:0]           direction,
  input  logic [5:0]           piece_count,
  input  logic                 game_over,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 result_ok,
  output logic [5:0]           accepted_cnt,
  output logic [REJ_CNT_W-1:0] rejected_cnt,
  output logic                 done,
  output logic [7:0]           last_reject
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [5:0]  count_before;
  logic [7:0]  head;
  logic        full, empty, push, pop, ok;
  assign head          = mem[rd_ptr];
  assign full          = level == (AW+1)'(FIFO_DEPTH);
  assign empty         = level == '0;
  assign host.in_ready = !full && state != DONE;
  assign push          = host.in_valid && host.in_ready;
  assign pop           = state == IDLE && !game_over && !empty;
  assign ok            = piece_count != count_before;
  assign busy          = !empty || state != IDLE;
  assign done          = state == DONE;
  // game_over outranks a pending pop; ISSUE and CHECK are fixed single cycles
  always_comb begin
    state_nx = state == IDLE  ? (game_over ? DONE : (!empty ? ISSUE : IDLE)) :
               state == ISSUE ? CHECK :
               state == CHECK ? IDLE : DONE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // queue storage needs no reset; validity is tracked by level
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host.in_data;
  end
  // queue pointers; everything still queued is dropped once the game is over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (state == DONE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level  <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // engine inputs carry the move only in the cycle after the pop, otherwise parked off-board
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piece_x      <= '0;
      piece_y      <= '0;
      direction    <= '0;
      count_before <= '0;
    end else begin
      piece_x      <= pop ? head[7:5] : 3'd0;
      piece_y      <= pop ? head[4:2] : 3'd0;
      direction    <= pop ? head[1:0] : 2'd0;
      count_before <= pop ? piece_count : count_before;
    end
  end
  // a move counts as accepted when the engine's piece count changed across the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
      accepted_cnt <= '0;
      rejected_cnt <= '0;
    end else begin
      result_valid <= state == CHECK;
      result_ok    <= state == CHECK && ok;
      accepted_cnt <= accepted_cnt + 6'(state == CHECK && ok);
      rejected_cnt <= rejected_cnt + REJ_CNT_W'(state == CHECK && !ok && !(&rejected_cnt));
    end
  end
`ifdef SOLITAIRE_PLAYER_REJECT_LOG_EN
  logic [7:0] mv_byte;
  // remember the byte in flight so a rejection can log it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_byte     <= '0;
      last_reject <= '0;
    end else begin
      mv_byte     <= pop ? head : mv_byte;
      last_reject <= (state == CHECK && !ok) ? mv_byte : last_reject;
    end
  end
`else
  assign last_reject = 8'd0;
`endif
endmodule

// File: tb/tb_solitaire_move_player.sv
// tb_solitaire_move_player: directed test of the move player against an English-board peg solitaire engine stub
module tb_solitaire_move_player;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] piece_x, piece_y;
  logic [1:0] direction;
  logic [5:0] piece_count;
  logic game_over;
  logic busy, result_valid, result_ok, done;
  logic [5:0] accepted_cnt;
  logic [7:0] rejected_cnt;
  logic [7:0] last_reject;
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int nz_cycles = 0;
  int viol = 0;
  bit prev_nz = 1'b0;
  bit res_q[$];
  logic board [7][7];
  int ddx, ddy, sx, sy, mx, my, tx, ty;
  logic legal;
  solitaire_move_player_if host_if();
  solitaire_move_player dut (
    .clk(clk), .rst_n(rst_n), .host(host_if),
    .piece_x(piece_x), .piece_y(piece_y), .direction(direction),
    .piece_count(piece_count), .game_over(game_over),
    .busy(busy), .result_valid(result_valid), .result_ok(result_ok),
    .accepted_cnt(accepted_cnt), .rejected_cnt(rejected_cnt),
    .done(done), .last_reject(last_reject)
  );
  always #5 clk = ~clk;
  function automatic bit on_board(input int x, input int y);
    return x >= 0 && x < 7 && y >= 0 && y < 7 && ((x >= 2 && x <= 4) || (y >= 2 && y <= 4));
  endfunction
  always_comb begin
    ddx = direction == 2'd0 ? -1 : (direction == 2'd1 ? 1 : 0);
    ddy = direction == 2'd2 ? -1 : (direction == 2'd3 ? 1 : 0);
    sx = int'(piece_x);
    sy = int'(piece_y);
    mx = sx + ddx;
    my = sy + ddy;
    tx = sx + 2 * ddx;
    ty = sy + 2 * ddy;
    legal = 1'b0;
    if (on_board(sx, sy) && on_board(mx, my) && on_board(tx, ty))
      legal = board[sx][sy] && board[mx][my] && !board[tx][ty];
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int x = 0; x < 7; x++)
        for (int y = 0; y < 7; y++)
          board[x][y] <= on_board(x, y) && !(x == 3 && y == 3);
      piece_count <= 6'd32;
    end else if (legal) begin
      board[sx][sy] <= 1'b0;
      board[mx][my] <= 1'b0;
      board[tx][ty] <= 1'b1;
      piece_count <= piece_count - 6'd1;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid) res_q.push_back(result_ok);
      if ({piece_x, piece_y, direction} != 8'd0) begin
        nz_cycles++;
        if (prev_nz) viol++;
        prev_nz = 1'b1;
      end else prev_nz = 1'b0;
    end else prev_nz = 1'b0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    int n = 0;
    host_if.in_valid = 1'b1;
    host_if.in_data = b;
    while (!host_if.in_ready && n < 64) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    chk("push_wait", 32'(n < 64), 32'd1);
    @(posedge clk);
    @(negedge clk);
    host_if.in_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] bp [8];
    bit exp_ok [8];
    int n;
    int nz0;
    bp = '{8'h29, 8'h29, 8'h63, 8'h6E, 8'hFC, 8'h76, 8'h7A, 8'hA8};
    exp_ok = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    game_over = 1'b0;
    host_if.in_valid = 1'b0;
    host_if.in_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_park", {piece_x, piece_y, direction}, 8'h00);
    chk("rst_in_ready", host_if.in_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_accepted", accepted_cnt, 6'd0);
    chk("rst_rejected", rejected_cnt, 8'd0);
    chk("rst_last_reject", last_reject, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h67);
    chk("legal_e0_park", {piece_x, piece_y, direction}, 8'h00);
    chk("legal_e0_busy", busy, 1'b1);
    @(negedge clk);
    chk("legal_issue", {piece_x, piece_y, direction}, 8'h67);
    @(negedge clk);
    chk("legal_e2_park", {piece_x, piece_y, direction}, 8'h00);
    chk("legal_count", piece_count, 6'd31);
    chk("legal_e2_rv", result_valid, 1'b0);
    @(negedge clk);
    chk("legal_rv", result_valid, 1'b1);
    chk("legal_ok", result_ok, 1'b1);
    chk("legal_accepted", accepted_cnt, 6'd1);
    @(negedge clk);
    chk("legal_rv_pulse", result_valid, 1'b0);
    push(8'h67);
    repeat (3) @(negedge clk);
    chk("illegal_rv", result_valid, 1'b1);
    chk("illegal_ok", result_ok, 1'b0);
    chk("illegal_rejected", rejected_cnt, 8'd1);
    chk("illegal_count", piece_count, 6'd31);
`ifdef SOLITAIRE_PLAYER_REJECT_LOG_EN
    chk("illegal_last_reject", last_reject, 8'h67);
`else
    chk("illegal_last_reject", last_reject, 8'h00);
`endif
    @(negedge clk);
    res_q.delete();
    stalls = 0;
    nz0 = nz_cycles;
    for (int i = 0; i < 8; i++) push(bp[i]);
    n = 0;
    while (res_q.size() < 8 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("bp_results", res_q.size(), 8);
    chk("bp_backpressure", 32'(stalls > 0), 32'd1);
    for (int i = 0; i < 8 && i < res_q.size(); i++)
      chk($sformatf("bp_ok_%0d", i), res_q[i], exp_ok[i]);
    chk("bp_accepted", accepted_cnt, 6'd5);
    chk("bp_rejected", rejected_cnt, 8'd5);
    chk("bp_count", piece_count, 6'd27);
    chk("bp_issue_cycles", nz_cycles - nz0, 8);
    chk("park_single_cycle", viol, 0);
`ifdef SOLITAIRE_PLAYER_REJECT_LOG_EN
    chk("bp_last_reject", last_reject, 8'h7A);
`else
    chk("bp_last_reject", last_reject, 8'h00);
`endif
    @(negedge clk);
    chk("bp_idle", busy, 1'b0);
    game_over = 1'b1;
    @(negedge clk);
    chk("go_done", done, 1'b1);
    chk("go_in_ready", host_if.in_ready, 1'b0);
    chk("go_busy", busy, 1'b1);
    host_if.in_valid = 1'b1;
    host_if.in_data = 8'h29;
    repeat (4) @(negedge clk);
    game_over = 1'b0;
    host_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("go_park", {piece_x, piece_y, direction}, 8'h00);
    chk("go_no_results", res_q.size(), 8);
    chk("go_accepted", accepted_cnt, 6'd5);
    chk("go_done_hold", done, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_done", done, 1'b0);
    chk("rel_in_ready", host_if.in_ready, 1'b1);
    chk("rel_accepted", accepted_cnt, 6'd0);
    chk("rel_count", piece_count, 6'd32);
    push(8'h67);
    @(negedge clk);
    chk("mid_issue", {piece_x, piece_y, direction}, 8'h67);
    rst_n = 1'b0;
    #1;
    chk("mid_park", {piece_x, piece_y, direction}, 8'h00);
    chk("mid_busy", busy, 1'b0);
    chk("mid_in_ready", host_if.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    res_q.delete();
    repeat (6) @(negedge clk);
    chk("mid_no_result", res_q.size(), 0);
    chk("mid_count", piece_count, 6'd32);
    chk("mid_rejected", rejected_cnt, 8'd0);
    chk("mid_idle", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/solitaire_move_player.md
Name: solitaire_move_player

Overview:
- Host-side move driver for the peg solitaire engine, on the opposite end of the engine's move interface.
- Accepts packed move bytes from the host over a valid/ready handshake and queues them in a small FIFO.
- Issues each queued move to the engine as exactly one cycle of piece_x/piece_y/direction, then classifies it as accepted or rejected from the engine's piece_count.
- Parks the engine inputs on a non-existent board square when idle, so no move can fire spuriously.

Parameters:
- FIFO_DEPTH, 4, move queue entries; power of 2, minimum 2.
- REJ_CNT_W, 8, width of the saturating rejected-move counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low; shared with the engine
- in_valid  input  1  host move byte valid
- in_data  input  8  move byte: [7:5]=x, [4:2]=y, [1:0]=direction (0 LEFT, 1 RIGHT, 2 UP, 3 DOWN)
- in_ready  output  1  move byte accepted on an edge where in_valid and in_ready are both 1
- piece_x  output  3  to engine
- piece_y  output  3  to engine
- direction  output  2  to engine
- piece_count  input  6  from engine
- game_over  input  1  from engine
- busy  output  1  FIFO non-empty or state not IDLE
- result_valid  output  1  one-cycle pulse per completed move
- result_ok  output  1  qualified by result_valid; 1 means the engine accepted the move
- accepted_cnt  output  6  moves accepted since reset
- rejected_cnt  output  REJ_CNT_W  moves rejected since reset; saturates at all-ones
- done  output  1  engine reported game over; terminal until reset
- last_reject  output  8  see Optional Feature

Behaviour:
- Reset values:
  - piece_x, piece_y, direction: 0 (park at (0,0) LEFT, a non-existent square, never legal).
  - FIFO empty; in_ready 1; busy, result_valid, result_ok, done: 0.
  - accepted_cnt, rejected_cnt, last_reject: 0.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full && state != DONE. No pass-through: the full flag is evaluated before any same-cycle pop.
  - Push and pop on the same edge are both allowed.
  - Read order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
- State machine, states IDLE, ISSUE, CHECK, DONE:
  - IDLE:
    - If game_over=1, go to DONE; this has priority over a pop.
    - Else if the FIFO is non-empty: pop, register the byte fields onto piece_x/piece_y/direction, capture count_before <= piece_count, go to ISSUE.
  - ISSUE: lasts exactly 1 cycle; the engine commits the move at its end. On exit, outputs return to the park position and the state goes to CHECK.
  - CHECK (1 cycle):
    - ok = (piece_count != count_before).
    - On exit: result_valid=1 and result_ok=ok for exactly the next cycle.
    - If ok, accepted_cnt increments; otherwise rejected_cnt increments, saturating.
    - Return to IDLE.
  - DONE:
    - done=1, in_ready=0, outputs parked.
    - Queued entries are discarded; busy reflects only state (busy=1).
    - Left only by reset.
- Latency:
  - Byte pushed at edge E0 into an empty FIFO with state IDLE: move is visible on the engine inputs during cycle E1..E2; engine commits at E2; result_valid is high during E3..E4.
  - Throughput is 1 move per 3 cycles.
- accepted_cnt wraps mod 64; this cannot occur in practice, since the board allows at most 31 moves.
- An out-of-board or illegal move is not filtered here; the engine ignores it and it is reported as a reject.
- Reset asserted mid-operation clears everything immediately. Engine inputs go straight to park, so no partial move reaches the engine.

Optional Feature:
- Macro: SOLITAIRE_PLAYER_REJECT_LOG_EN.
- Defined: last_reject captures the full 8-bit move byte of each rejected move, updated on the same edge as rejected_cnt; it holds its value otherwise.
- Undefined: last_reject is tied to 0 and no capture register exists.

Test Plan:
- Reset: hold rst_n=0 -> piece_x=0, piece_y=0, direction=0, in_ready=1, done=0, counters 0.
- Legal move: push 0x67 (x3, y1, DOWN) on a fresh engine -> engine inputs show (3,1,3) for exactly 1 cycle; piece_count 32->31; result_valid=1 with result_ok=1 at E3; accepted_cnt=1.
- Illegal move: then push 0x67 again -> piece_count stays 31; result_ok=0; rejected_cnt=1. With the macro defined, last_reject=0x67.
- Backpressure: push 8 bytes back-to-back with FIFO_DEPTH=4 -> in_ready drops at least once; 8 result_valid pulses appear in push order; engine inputs are at (0,0) on every cycle outside ISSUE.
- Game over: engine stub drives game_over=1 while IDLE -> done=1 and in_ready=0 within 1 cycle; further in_valid is ignored; done holds until rst_n.
- Reset during ISSUE: assert rst_n=0 in the ISSUE cycle -> outputs parked immediately, FIFO empty, no result_valid pulse after release.
